// File: rtl/ysyx_22041211_ifid_buffer_pkg.sv
// Shared definitions for the IF/ID elastic buffer.
//   ifid_state_e : buffer occupancy state (EMPTY / ONE / TWO; 2'b11 is illegal)
//   IFID_NOP     : instruction the decode stage uses while out_valid_o is low
package ysyx_22041211_ifid_buffer_pkg;

  typedef enum logic [1:0] {
    IFID_EMPTY = 2'b00,
    IFID_ONE   = 2'b01,
    IFID_TWO   = 2'b10
  } ifid_state_e;

  localparam logic [31:0] IFID_NOP = 32'h00000013;

endpackage

// File: rtl/ysyx_22041211_ifid_buffer_if.sv
// Fetch/decode handshake bundle for the IF/ID buffer.
//   flush_i                          : redirect, drop everything buffered and incoming
//   in_valid_i / in_ready_o          : fetch-side handshake carrying in_pc_i / in_inst_i
//   out_valid_o / out_ready_i        : decode-side handshake carrying out_pc_o / out_inst_o
// Modports: slave = the buffer, master = the fetch/decode environment driving it.
interface ysyx_22041211_ifid_buffer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  flush_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [ADDR_WIDTH-1:0] in_pc_i;
  logic [DATA_WIDTH-1:0] in_inst_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [ADDR_WIDTH-1:0] out_pc_o;
  logic [DATA_WIDTH-1:0] out_inst_o;

  modport slave (
    input  flush_i, in_valid_i, in_pc_i, in_inst_i, out_ready_i,
    output in_ready_o, out_valid_o, out_pc_o, out_inst_o
  );

  modport master (
    output flush_i, in_valid_i, in_pc_i, in_inst_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_pc_o, out_inst_o
  );
endinterface

// File: rtl/ysyx_22041211_ifid_entry_reg.sv
// Load-enabled register holding one {pc, inst} entry of the IF/ID buffer.
//   clk, rst : clock, synchronous active-high reset (clears the entry to 0)
//   load     : capture d on this edge
//   d / q    : entry in / entry out, WIDTH bits
module ysyx_22041211_ifid_entry_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  // NOTE: the entry is cleared on reset because out_pc_o/out_inst_o must
  // read 0 out of reset; a plain data register would otherwise skip reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ysyx_22041211_ifid_buffer.sv
// Two-entry elastic buffer (main + skid) between fetch and decode.
// Decode sees the main entry straight from flops; the skid entry absorbs the
// one instruction fetch may push in the cycle decode stalls, so in_ready_o
// depends on state only and never on out_ready_i.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : ysyx_22041211_ifid_buffer_if.slave (flush, in/out handshakes)
// Optional build macro YSYX_22041211_IFID_PERF_EN adds 32-bit wrapping counters:
//   perf_stall_cnt_o      : cycles with out_valid_o & ~out_ready_i
//   perf_bubble_cnt_o     : cycles with ~out_valid_o outside reset
//   perf_flush_drop_cnt_o : entries discarded by flushes (buffered + incoming)
module ysyx_22041211_ifid_buffer
  import ysyx_22041211_ifid_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  ysyx_22041211_ifid_buffer_if.slave bus
`ifdef YSYX_22041211_IFID_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_bubble_cnt_o,
  output logic [31:0] perf_flush_drop_cnt_o
`endif
);

  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  ifid_state_e        state_q;
  ifid_state_e        state_d;
  logic               in_fire;
  logic               out_fire;
  logic               main_load;
  logic               main_from_skid;
  logic               skid_load;
  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] main_d;
  logic [ENTRY_W-1:0] main_q;
  logic [ENTRY_W-1:0] skid_q;

  assign bus.in_ready_o  = (state_q != IFID_TWO) & ~rst;
  assign bus.out_valid_o = (state_q != IFID_EMPTY);

  assign in_fire  = bus.in_valid_i & bus.in_ready_o & ~bus.flush_i;
  assign out_fire = bus.out_valid_o & bus.out_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IFID_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (bus.flush_i) begin
      // Only the state clears; stale data stays in the entry registers.
      state_d = IFID_EMPTY;
    end else begin
      case (state_q)
        IFID_EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = IFID_ONE;
          end
        end
        IFID_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = IFID_TWO;
          end else if (out_fire) begin
            state_d = IFID_EMPTY;
          end
        end
        IFID_TWO: begin
          // in_ready_o is low here, so only the drain case exists.
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = IFID_ONE;
          end
        end
        default: state_d = IFID_EMPTY;  // illegal 2'b11 recovers
      endcase
    end
  end

  assign in_entry = {bus.in_pc_i, bus.in_inst_i};
  assign main_d   = main_from_skid ? skid_q : in_entry;

  ysyx_22041211_ifid_entry_reg #(.WIDTH(ENTRY_W)) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (main_load),
    .d    (main_d),
    .q    (main_q)
  );

  ysyx_22041211_ifid_entry_reg #(.WIDTH(ENTRY_W)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (skid_load),
    .d    (in_entry),
    .q    (skid_q)
  );

  assign bus.out_pc_o   = main_q[ENTRY_W-1 -: ADDR_WIDTH];
  assign bus.out_inst_o = main_q[DATA_WIDTH-1:0];

`ifdef YSYX_22041211_IFID_PERF_EN
  logic [1:0]  live_cnt;
  logic [31:0] drop_add;

  always_comb begin
    live_cnt = 2'd0;
    case (state_q)
      IFID_ONE: live_cnt = 2'd1;
      IFID_TWO: live_cnt = 2'd2;
      default:  live_cnt = 2'd0;
    endcase
  end

  // An entry decode takes in the flush cycle is consumed, not dropped.
  assign drop_add = 32'(live_cnt) - 32'(out_fire) + 32'(bus.in_valid_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt_o      <= '0;
      perf_bubble_cnt_o     <= '0;
      perf_flush_drop_cnt_o <= '0;
    end else begin
      if (bus.out_valid_o && !bus.out_ready_i) begin
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      end
      if (!bus.out_valid_o) begin
        perf_bubble_cnt_o <= perf_bubble_cnt_o + 32'd1;
      end
      if (bus.flush_i) begin
        perf_flush_drop_cnt_o <= perf_flush_drop_cnt_o + drop_add;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22041211_ifid_buffer.sv
// Directed bench for ysyx_22041211_ifid_buffer. A queue holds the entries the
// buffer should contain; accepted pushes append, decode handshakes pop and
// compare the head, flushes and resets empty it. Build with
// YSYX_22041211_IFID_PERF_EN defined to also check the performance counters.
module tb_ysyx_22041211_ifid_buffer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic   clk;
  logic   rst;
  int     checks = 0;
  int     errors = 0;
  entry_t sb[$];

`ifdef YSYX_22041211_IFID_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_bubble_cnt;
  logic [31:0] perf_flush_drop_cnt;
  logic [31:0] stall_m  = '0;
  logic [31:0] bubble_m = '0;
  logic [31:0] drop_m   = '0;
`endif

  ysyx_22041211_ifid_buffer_if bus ();

  ysyx_22041211_ifid_buffer dut (
    .clk                   (clk),
    .rst                   (rst),
    .bus                   (bus)
`ifdef YSYX_22041211_IFID_PERF_EN
    ,
    .perf_stall_cnt_o      (perf_stall_cnt),
    .perf_bubble_cnt_o     (perf_bubble_cnt),
    .perf_flush_drop_cnt_o (perf_flush_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5a5a_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the queue model,
  // advance the model by what the edge should do, then move to the next negedge.
  task automatic cycle(input logic r, input logic f, input logic iv,
                       input logic [31:0] pc, input logic ordy, input string tag);
    logic   exp_valid;
    logic   exp_ready;
    logic   in_fire;
    logic   out_fire;
    entry_t head;
    rst             = r;
    bus.flush_i     = f;
    bus.in_valid_i  = iv;
    bus.in_pc_i     = pc;
    bus.in_inst_i   = inst_of(pc);
    bus.out_ready_i = ordy;
    #1;
    exp_valid = (sb.size() != 0);
    exp_ready = (sb.size() < 2) && !r;
    check({tag, ".in_ready"},  32'(bus.in_ready_o),  32'(exp_ready));
    check({tag, ".out_valid"}, 32'(bus.out_valid_o), 32'(exp_valid));
    if (exp_valid) begin
      head = sb[0];
      check({tag, ".out_pc"},   bus.out_pc_o,   head.pc);
      check({tag, ".out_inst"}, bus.out_inst_o, head.inst);
    end
    out_fire = exp_valid && ordy;
    in_fire  = iv && exp_ready && !f;
`ifdef YSYX_22041211_IFID_PERF_EN
    if (r) begin
      stall_m  = '0;
      bubble_m = '0;
      drop_m   = '0;
    end else begin
      if (exp_valid && !ordy) stall_m = stall_m + 32'd1;
      if (!exp_valid)         bubble_m = bubble_m + 32'd1;
      if (f) drop_m = drop_m + 32'(sb.size()) - 32'(out_fire) + 32'(iv);
    end
`endif
    if (r) begin
      sb.delete();
    end else begin
      if (out_fire) void'(sb.pop_front());
      if (f) begin
        sb.delete();
      end else if (in_fire) begin
        sb.push_back('{pc: pc, inst: inst_of(pc)});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst             = 1'b1;
    bus.flush_i     = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.in_pc_i     = '0;
    bus.in_inst_i   = '0;
    bus.out_ready_i = 1'b0;
    @(negedge clk);

    // Reset: in_ready low during reset, outputs cleared.
    cycle(1, 0, 0, 32'h0, 0, "rst0");
    cycle(1, 0, 1, 32'h0, 1, "rst1");
    check("rst.out_pc",   bus.out_pc_o,   32'h0);
    check("rst.out_inst", bus.out_inst_o, 32'h0);

    // Back-to-back stream with decode always ready.
    cycle(0, 0, 1, 32'h8000_0000, 1, "str0");
    cycle(0, 0, 1, 32'h8000_0004, 1, "str1");
    cycle(0, 0, 1, 32'h8000_0008, 1, "str2");
    cycle(0, 0, 0, 32'h0,         1, "str3");
    cycle(0, 0, 0, 32'h0,         1, "str4");

    // Backpressure: fill both entries, third push must be refused.
    cycle(0, 0, 1, 32'h8000_0000, 0, "bp0");
    cycle(0, 0, 1, 32'h8000_0004, 0, "bp1");
    cycle(0, 0, 1, 32'h8000_0008, 0, "bp2");
    cycle(0, 0, 0, 32'h0,         1, "bp3");
    cycle(0, 0, 0, 32'h0,         1, "bp4");
    cycle(0, 0, 0, 32'h0,         1, "bp5");

    // Flush while full with an incoming instruction that must be dropped.
    cycle(0, 0, 1, 32'h8000_0000, 0, "fl0");
    cycle(0, 0, 1, 32'h8000_0004, 0, "fl1");
    cycle(0, 1, 1, 32'h8000_000c, 0, "fl2");
    cycle(0, 0, 0, 32'h0,         1, "fl3");
    cycle(0, 0, 0, 32'h0,         1, "fl4");

    // Simultaneous push and pop while holding one entry.
    cycle(0, 0, 1, 32'h8000_0000, 0, "sim0");
    cycle(0, 0, 1, 32'h8000_0010, 1, "sim1");
    cycle(0, 0, 0, 32'h0,         0, "sim2");
    cycle(0, 0, 0, 32'h0,         1, "sim3");
    cycle(0, 0, 0, 32'h0,         1, "sim4");

    // Reset with two entries held.
    cycle(0, 0, 1, 32'h8000_0020, 0, "mr0");
    cycle(0, 0, 1, 32'h8000_0024, 0, "mr1");
    cycle(1, 0, 0, 32'h0,         0, "mr2");
    check("mr.out_pc",   bus.out_pc_o,   32'h0);
    check("mr.out_inst", bus.out_inst_o, 32'h0);
    cycle(0, 0, 0, 32'h0,         1, "mr3");
    cycle(0, 0, 1, 32'h8000_0028, 1, "mr4");
    cycle(0, 0, 0, 32'h0,         1, "mr5");

`ifdef YSYX_22041211_IFID_PERF_EN
    // Three stall cycles, then a flush dropping two entries plus the incoming one.
    check("perf.pre_bubble", perf_bubble_cnt, bubble_m);
    cycle(1, 0, 0, 32'h0,         0, "pf0");
    cycle(0, 0, 1, 32'h8000_0030, 0, "pf1");
    cycle(0, 0, 1, 32'h8000_0034, 0, "pf2");
    cycle(0, 0, 0, 32'h0,         0, "pf3");
    cycle(0, 1, 1, 32'h8000_0038, 0, "pf4");
    check("perf.stall",      perf_stall_cnt,      32'd3);
    check("perf.flush_drop", perf_flush_drop_cnt, 32'd3);
    check("perf.bubble",     perf_bubble_cnt,     bubble_m);
    check("perf.stall_m",    perf_stall_cnt,      stall_m);
    check("perf.drop_m",     perf_flush_drop_cnt, drop_m);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
